// File: rtl/rr_bus_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_bus_arbiter_pkg : shared constants, state encoding and helpers. Rev 1.0
// ---------------------------------------------------------------------------
package rr_bus_arbiter_pkg;

   localparam int NREQ   = 4;
   localparam int SEL_W  = 2;
   localparam int DATA_W = 32;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_bus_arbiter_if : request/data/grant bundle; RR_LOCK_EN adds lock. Rev 1.0
// ---------------------------------------------------------------------------
interface rr_bus_arbiter_if;
   import rr_bus_arbiter_pkg::*;

   logic [NREQ-1:0]   req;
   logic [DATA_W-1:0] d0;
   logic [DATA_W-1:0] d1;
   logic [DATA_W-1:0] d2;
   logic [DATA_W-1:0] d3;
   logic [NREQ-1:0]   gnt;
   logic [SEL_W-1:0]  sel;
   logic              valid;
   logic [DATA_W-1:0] y;
`ifdef RR_LOCK_EN
   logic              lock;
`endif

   modport master (
`ifdef RR_LOCK_EN
      output lock,
`endif
      output req, d0, d1, d2, d3,
      input  gnt, sel, valid, y
   );

   modport slave (
`ifdef RR_LOCK_EN
      input  lock,
`endif
      input  req, d0, d1, d2, d3,
      output gnt, sel, valid, y
   );

endinterface
`default_nettype wire

// File: rtl/mux4_32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux4_32 : 32-bit 4:1 word multiplexer library cell. Rev 1.0
// ---------------------------------------------------------------------------
module mux4_32 (
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [31:0] d3,
   input  logic [1:0]  sel,
   output logic [31:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick : first set request at or after start (mod NREQ), excl bits masked. Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick
   import rr_bus_arbiter_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] start,
   input  logic [NREQ-1:0]  excl,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [NREQ-1:0] w_cand;

   assign w_cand = req & ~excl;

   // Scan farthest-first so the nearest candidate to start wins.
   always_comb begin
      found = 1'b0;
      idx   = start;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_cand[start + SEL_W'(k)]) begin
            found = 1'b1;
            idx   = start + SEL_W'(k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_bus_arbiter : four-way round-robin bus arbiter with bounded-hold
// preemption; macro RR_LOCK_EN adds a lock input that suspends preemption. Rev 1.0
// ---------------------------------------------------------------------------
module rr_bus_arbiter
   import rr_bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic           clk,
   input  logic           rst,
   rr_bus_arbiter_if.slave bus
);

   localparam logic [HOLD_W-1:0] c_hold_max =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   state_t             r_state;
   logic [NREQ-1:0]    r_gnt;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   r_ptr;
   logic               r_valid;
   logic [HOLD_W-1:0]  r_hold;

   logic               w_own;
   logic               w_owner_req;
   logic               w_lock;
   logic [SEL_W-1:0]   w_start;
   logic [NREQ-1:0]    w_excl;
   logic               w_found;
   logic [SEL_W-1:0]   w_idx;
   logic               w_release;
   logic               w_preempt;
   logic               w_new_grant;
   logic [DATA_W-1:0]  w_mux;

`ifdef RR_LOCK_EN
   assign w_lock = bus.lock;
`else
   assign w_lock = 1'b0;
`endif

   assign w_own       = (r_state == OWN);
   assign w_owner_req = bus.req[r_sel];

   // While owning, search starts just past the owner and skips it.
   assign w_start = w_own ? r_sel + SEL_W'(1) : r_ptr;
   assign w_excl  = w_own ? onehot(r_sel) : '0;

   rr_pick u_pick (
      .req   (bus.req),
      .start (w_start),
      .excl  (w_excl),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_release   = w_own && !w_owner_req;
   assign w_preempt   = w_own && w_owner_req && (MAX_HOLD != 0) && !w_lock &&
                        (r_hold == c_hold_max) && w_found;
   assign w_new_grant = ((!w_own || w_release) && w_found) || w_preempt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_hold  <= '0;
      end else begin
         if (w_release || w_preempt) begin
            r_ptr <= r_sel + SEL_W'(1);
         end
         if (w_new_grant) begin
            r_state <= OWN;
            r_gnt   <= onehot(w_idx);
            r_sel   <= w_idx;
            r_valid <= 1'b1;
            r_hold  <= '0;
         end else if (w_release) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
         end else if (w_own && !w_lock && (r_hold != c_hold_max)) begin
            r_hold <= r_hold + HOLD_W'(1);
         end
      end
   end

   mux4_32 u_mux (
      .d0  (bus.d0),
      .d1  (bus.d1),
      .d2  (bus.d2),
      .d3  (bus.d3),
      .sel (r_sel),
      .y   (w_mux)
   );

   assign bus.gnt   = r_gnt;
   assign bus.sel   = r_sel;
   assign bus.valid = r_valid;
   assign bus.y     = r_valid ? w_mux : '0;

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_bus_arbiter : directed self-checking bench for rr_bus_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
module tb_rr_bus_arbiter;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   logic [31:0] dv [4];

   rr_bus_arbiter_if bus ();

   rr_bus_arbiter #(
      .MAX_HOLD (8),
      .HOLD_W   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [3:0] egnt, input logic [31:0] ey);
      chk({tag, ".gnt"},   {28'd0, bus.gnt},   {28'd0, egnt});
      chk({tag, ".valid"}, {31'd0, bus.valid}, {31'd0, |egnt});
      chk({tag, ".y"},     bus.y,              ey);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      dv[0] = 32'h1111_0000;
      dv[1] = 32'h2222_0001;
      dv[2] = 32'h3333_0002;
      dv[3] = 32'h4444_0003;
      bus.d0  = dv[0];
      bus.d1  = dv[1];
      bus.d2  = dv[2];
      bus.d3  = dv[3];
`ifdef RR_LOCK_EN
      bus.lock = 1'b0;
`endif

      // 1: reset with all requests high, then first grant goes to master 0
      rst     = 1'b1;
      bus.req = 4'b1111;
      tick();
      tick();
      chk_bus("rst", 4'b0000, 32'h0);
      chk("rst.sel", {30'd0, bus.sel}, 32'd0);
      rst = 1'b0;
      tick();
      chk_bus("first", 4'b0001, dv[0]);
      chk("first.sel", {30'd0, bus.sel}, 32'd0);
      bus.req = 4'b0000;
      tick();
      chk_bus("drop0", 4'b0000, 32'h0);

      // 2: lone request from master 2, then release leaves ptr at 3
      dv[2]   = 32'hDEAD_BEEF;
      bus.d2  = dv[2];
      bus.req = 4'b0100;
      tick();
      chk_bus("lone2", 4'b0100, 32'hDEAD_BEEF);
      chk("lone2.sel", {30'd0, bus.sel}, 32'd2);
      bus.req = 4'b0000;
      tick();
      chk_bus("rel2", 4'b0000, 32'h0);
      chk("rel2.selhold", {30'd0, bus.sel}, 32'd2);
      bus.req = 4'b1111;
      tick();
      chk_bus("ptr3", 4'b1000, dv[3]);
      bus.req = 4'b0000;
      tick();
      chk_bus("rel3", 4'b0000, 32'h0);

      // 3: full rotation from ptr=0, each master holding two cycles
      bus.req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         logic [3:0] eg;
         eg = 4'b0001 << i;
         tick();
         chk_bus($sformatf("rot%0d.a", i), eg, dv[i]);
         tick();
         chk_bus($sformatf("rot%0d.b", i), eg, dv[i]);
         case (i)
            0:       bus.req = 4'b1110;
            1:       bus.req = 4'b1100;
            2:       bus.req = 4'b1000;
            default: bus.req = 4'b0001;
         endcase
      end
      tick();
      chk_bus("rot.wrap", 4'b0001, dv[0]);
      bus.req = 4'b0000;
      tick();
      chk_bus("rot.idle", 4'b0000, 32'h0);

      // 4: master 1 preempted after eight granted cycles by master 3
      bus.req = 4'b0010;
      tick();
      chk_bus("pre.e0", 4'b0010, dv[1]);
      tick();
      chk_bus("pre.e1", 4'b0010, dv[1]);
      bus.req = 4'b1010;
      for (int k = 2; k <= 7; k++) begin
         tick();
         chk_bus($sformatf("pre.e%0d", k), 4'b0010, dv[1]);
      end
      tick();
      chk_bus("pre.e8", 4'b1000, dv[3]);
      chk("pre.sel", {30'd0, bus.sel}, 32'd3);
      bus.req = 4'b0000;
      tick();
      chk_bus("pre.idle", 4'b0000, 32'h0);

      // 5: lone owner keeps bus; saturated counter preempts at once when another asks
      bus.req = 4'b0001;
      tick();
      chk_bus("sat.e0", 4'b0001, dv[0]);
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk_bus($sformatf("sat.e%0d", k), 4'b0001, dv[0]);
      end
      bus.req = 4'b0101;
      tick();
      chk_bus("sat.pre", 4'b0100, dv[2]);
      bus.req = 4'b0000;
      tick();
      chk_bus("sat.idle", 4'b0000, 32'h0);

`ifdef RR_LOCK_EN
      // 6: lock raised at saturation suppresses preemption until it falls
      bus.req = 4'b0010;
      tick();
      chk_bus("lk.e0", 4'b0010, dv[1]);
      tick();
      bus.req = 4'b1010;
      for (int k = 2; k <= 7; k++) tick();
      chk_bus("lk.e7", 4'b0010, dv[1]);
      bus.lock = 1'b1;
      for (int k = 8; k <= 11; k++) begin
         tick();
         chk_bus($sformatf("lk.e%0d", k), 4'b0010, dv[1]);
      end
      bus.lock = 1'b0;
      tick();
      chk_bus("lk.e12", 4'b1000, dv[3]);
      bus.req = 4'b0000;
      tick();
      chk_bus("lk.idle", 4'b0000, 32'h0);
`endif

      // reset mid-grant drops the grant regardless of requests
      bus.req = 4'b1111;
      tick();
      chk("mid.valid", {31'd0, bus.valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk_bus("mid.rst", 4'b0000, 32'h0);
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
Round-robin arbiter that shares one 32-bit datapath bus between four requesters.
- Registers a one-hot grant and a 2-bit mux select.
- Routes the owner's 32-bit data word to the shared bus output through a 4:1 word mux.
- Sits between the four bus masters and the shared downstream port; guarantees fairness with a bounded-hold preemption counter.

Parameters:
MAX_HOLD, 8, cycles an owner may keep the bus while another requester waits; range 1..15; 0 disables preemption
HOLD_W, 4, width of the hold counter; must hold MAX_HOLD

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
REQ  input  4  request per master; held high while the bus is wanted
D0   input  32  master 0 data
D1   input  32  master 1 data
D2   input  32  master 2 data
D3   input  32  master 3 data
GNT  output  4  registered one-hot grant; all-zero when the bus is idle
SEL  output  2  registered binary index of the owner; drives the word mux
VALID  output  1  registered; high while any grant is active
Y  output  32  shared bus data: D[SEL] when VALID, else 32'h0 (combinational from registered SEL/VALID)

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous, active-high, sampled on the CLK rising edge.
- Reset values: state=IDLE, GNT=0, SEL=0, VALID=0, Y=0, ptr=0, hold_cnt=0.
- Reset mid-grant drops GNT/VALID on the next edge regardless of REQ.
- ptr (2 bits) is the highest-priority index. Search order is ptr, ptr+1, ... mod 4.
- IDLE:
  - If REQ != 0, grant the first set bit in search order.
  - Latency: REQ sampled at edge n gives GNT/SEL/VALID at edge n (visible from cycle n+1).
  - Enter OWN; hold_cnt=0.
- OWN, owner o:
  - Release: if REQ[o]==0, then ptr=o+1 mod 4. If any other REQ is set, grant the next requester after o on the same edge (zero-bubble handoff; GNT changes directly one-hot to one-hot). Otherwise GNT=0, VALID=0, go IDLE.
  - Preempt: if REQ[o]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1 and another REQ is set, grant the next requester after o and set ptr=o+1 mod 4. Master o must re-request and wait its turn.
  - Otherwise keep the grant. hold_cnt increments, saturating at MAX_HOLD-1. If no other requester is waiting at saturation, the owner keeps the bus indefinitely.
  - hold_cnt is cleared on every new grant.
- Invariants: GNT is always one-hot or zero. VALID == |GNT. SEL == index of GNT when VALID; SEL holds its last value when idle.
- Simultaneous requests in IDLE are resolved purely by ptr order.
- A request that rises on the same edge as a release is eligible for that handoff.
- Any REQ bit may drop at any time; a non-owner drop has no effect.

Optional Feature:
RR_LOCK_EN
- Compiled in: adds input LOCK (1 bit).
  - While in OWN with REQ[o]==1 and LOCK==1, preemption is suppressed and hold_cnt is frozen.
  - Release on REQ drop still applies.
  - LOCK is ignored in IDLE.
- Compiled out: no LOCK port; preemption always applies per MAX_HOLD.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=1'b0, OWN=1'b1
  - requester count constant NREQ=4 and select width 2
  - the 32-bit data-width constant
- One natural sub-module: rr_pick. It is combinational; it takes req[3:0], start[1:0] and an exclude-owner mask, and returns found plus a 2-bit index.
- Word routing instantiates the team's existing 32-bit 4:1 mux library cell, with Y zero-gated by VALID.

Test Plan:
1. Reset with REQ=4'b1111 held -> GNT=0, VALID=0, Y=0. After RST falls, the first edge gives GNT=4'b0001, SEL=0, Y=D0.
2. REQ=4'b0100 alone, D2=32'hDEADBEEF -> GNT=4'b0100 one edge later, Y=32'hDEADBEEF. Drop REQ -> GNT=0, Y=0 next edge, ptr=3.
3. REQ=4'b1111, masters drop REQ after 2 cycles each, from ptr=0 -> grant sequence 0,1,2,3,0 with back-to-back handoffs and no idle cycle.
4. MAX_HOLD=8: master 1 holds REQ, master 3 requests at cycle 2 -> master 1 is preempted on its 8th granted cycle and GNT=4'b1000 on the next.
5. Master 0 alone holds for 20 cycles -> GNT stays 4'b0001; hold_cnt saturates at 7 with no preemption.
6. RR_LOCK_EN, LOCK=1 under scenario 4 -> no preemption. LOCK falls at cycle 12 -> preempted on the next edge where REQ[3] is set.
